instr_sequencer: RTL and testbench



---
 rtl/mips_ctrl_pkg.sv | 40 ++++
 rtl/ack_timer.sv | 33 +++
 rtl/instr_sequencer.sv | 96 +++++++++
 tb/tb_instr_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared types and defaults for the multicycle MIPS control sequencer.
package mips_ctrl_pkg;

    localparam int DEF_CNT_W       = 32;
    localparam int DEF_ACK_TIMEOUT = 16;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_ERROR  = 3'd7
    } state_t;

    typedef struct packed {
        logic busy;
        logic halted;
        logic error;
        logic imem_req;
        logic dmem_req;
        logic pc_en;
    } ctrl_t;

    // Output levels that are a pure function of the state being entered.
    function automatic ctrl_t ctrl_of(input state_t s);
        ctrl_t c;
        c          = '0;
        c.busy     = s inside {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB};
        c.halted   = (s == S_HALT);
        c.error    = (s == S_ERROR);
        c.imem_req = (s == S_FETCH);
        c.dmem_req = (s == S_MEM);
        c.pc_en    = (s == S_WB);
        return c;
    endfunction

endpackage

// File: rtl/ack_timer.sv
// Shared memory-ack wait counter; expire flags the last allowed un-acked cycle.
module ack_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    generate
        if (LIMIT == 0) begin : g_off
            assign expire = 1'b0;
        end else begin : g_on
            localparam int W = (LIMIT > 2) ? $clog2(LIMIT) : 1;
            logic [W-1:0] count;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    count <= '0;
                end else if (clr) begin
                    count <= '0;
                end else if (en) begin
                    count <= count + W'(1);
                end
            end

            assign expire = en && (count == W'(LIMIT - 1));
        end
    endgenerate

endmodule

// File: rtl/instr_sequencer.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory handshakes,
// run/step/halt control, ack-timeout trap and debug counters.
module instr_sequencer
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             step,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             ir_load,
    input  logic             write_reg,
    input  logic             write_mem,
    input  logic             read_mem,
    input  logic             halt_insn,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic             pc_en,
    output logic             reg_we,
    output logic             busy,
    output logic             halted,
    output logic             error,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret
);

    state_t state_q, state_nxt;
    ctrl_t  ctrl_q;
    logic   reg_we_q;
    logic   in_wait, wait_en, expire;

    assign in_wait = (state_q == S_FETCH) || (state_q == S_MEM);
    assign wait_en = ((state_q == S_FETCH) && !imem_ack) ||
                     ((state_q == S_MEM)   && !dmem_ack);

    // Held in clear outside FETCH/MEM, so every entry starts from zero.
    ack_timer #(.LIMIT(ACK_TIMEOUT)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (!in_wait),
        .en     (wait_en),
        .expire (expire)
    );

    always_comb begin
        // NOTE: default first so every path assigns state_nxt; no latch.
        state_nxt = state_q;
        case (state_q)
            S_IDLE:   if (run || step) state_nxt = S_FETCH;
            S_FETCH:  if (imem_ack) state_nxt = S_DECODE;
                      else if (expire) state_nxt = S_ERROR;
            S_DECODE: state_nxt = halt_insn ? S_HALT : S_EXEC;
            S_EXEC:   state_nxt = (write_mem || read_mem) ? S_MEM : S_WB;
            S_MEM:    if (dmem_ack) state_nxt = S_WB;
                      else if (expire) state_nxt = S_ERROR;
            S_WB:     state_nxt = run ? S_FETCH : S_IDLE;
            default:  state_nxt = state_q;
        endcase
    end

    // Outputs are registered from the next state, so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ctrl_q    <= '0;
            reg_we_q  <= 1'b0;
            cycle_cnt <= '0;
            instret   <= '0;
        end else begin
            // NOTE: non-blocking so all registers see pre-edge values.
            state_q  <= state_nxt;
            ctrl_q   <= ctrl_of(state_nxt);
            reg_we_q <= (state_nxt == S_WB) && write_reg;
            if (ctrl_q.busy)  cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (ctrl_q.pc_en) instret   <= instret + CNT_W'(1);
        end
    end

    assign state    = state_q;
    assign busy     = ctrl_q.busy;
    assign halted   = ctrl_q.halted;
    assign error    = ctrl_q.error;
    assign imem_req = ctrl_q.imem_req;
    assign dmem_req = ctrl_q.dmem_req;
    assign pc_en    = ctrl_q.pc_en;
    assign reg_we   = reg_we_q;
    assign dmem_we  = ctrl_q.dmem_req && write_mem;
    assign ir_load  = (state_q == S_FETCH) && imem_ack;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer (ACK_TIMEOUT = 4).
module tb_instr_sequencer;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_HALT   = 3'd6;
    localparam logic [2:0] ST_ERROR  = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n, run, step, imem_ack, write_reg, write_mem, read_mem, halt_insn, dmem_ack;
    logic        imem_req, ir_load, dmem_req, dmem_we, pc_en, reg_we, busy, halted, error;
    logic [2:0]  state;
    logic [31:0] cycle_cnt, instret;

    int passed = 0;
    int total  = 0;

    instr_sequencer #(.CNT_W(32), .ACK_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .step(step),
        .imem_req(imem_req), .imem_ack(imem_ack), .ir_load(ir_load),
        .write_reg(write_reg), .write_mem(write_mem), .read_mem(read_mem), .halt_insn(halt_insn),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .pc_en(pc_en), .reg_we(reg_we), .busy(busy), .halted(halted), .error(error),
        .state(state), .cycle_cnt(cycle_cnt), .instret(instret)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int limit, input string tag);
        int n = 0;
        while (state !== s && n < limit) begin
            tick();
            n++;
        end
        total++; if (state !== s) $display("FAIL %s state=%0d exp=%0d (timeout)", tag, state, s); else passed++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 0; step = 0; imem_ack = 0; dmem_ack = 0;
        write_reg = 0; write_mem = 0; read_mem = 0; halt_insn = 0;
        #2;
        total++; if (state !== ST_IDLE) $display("FAIL reset_state got=%0d exp=0", state); else passed++;
        total++; if ({imem_req, ir_load, dmem_req, dmem_we, pc_en, reg_we, busy, halted, error} !== 9'd0)
            $display("FAIL reset_outputs got=%b exp=000000000", {imem_req, ir_load, dmem_req, dmem_we, pc_en, reg_we, busy, halted, error});
        else passed++;
        total++; if (cycle_cnt !== 32'd0 || instret !== 32'd0) $display("FAIL reset_counters cycle=%0d instret=%0d exp=0/0", cycle_cnt, instret); else passed++;
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
    endtask

    task automatic test_alu();
        imem_ack = 1; write_reg = 1; run = 1;
        tick();
        total++; if (state !== ST_FETCH || imem_req !== 1'b1 || ir_load !== 1'b1)
            $display("FAIL alu_fetch state=%0d req=%b ir_load=%b exp=1/1/1", state, imem_req, ir_load); else passed++;
        tick();
        total++; if (state !== ST_DECODE || imem_req !== 1'b0 || ir_load !== 1'b0)
            $display("FAIL alu_decode state=%0d req=%b ir_load=%b exp=2/0/0", state, imem_req, ir_load); else passed++;
        tick();
        total++; if (state !== ST_EXEC) $display("FAIL alu_exec state=%0d exp=3", state); else passed++;
        tick();
        total++; if (state !== ST_WB || pc_en !== 1'b1 || reg_we !== 1'b1 || dmem_req !== 1'b0)
            $display("FAIL alu_wb state=%0d pc_en=%b reg_we=%b dmem_req=%b exp=5/1/1/0", state, pc_en, reg_we, dmem_req); else passed++;
        run = 0;
        tick();
        total++; if (state !== ST_IDLE || pc_en !== 1'b0 || reg_we !== 1'b0)
            $display("FAIL alu_idle state=%0d pc_en=%b reg_we=%b exp=0/0/0", state, pc_en, reg_we); else passed++;
        total++; if (instret !== 32'd1 || cycle_cnt !== 32'd4)
            $display("FAIL alu_counters instret=%0d cycle=%0d exp=1/4", instret, cycle_cnt); else passed++;
    endtask

    task automatic test_store();
        int we_cnt = 0;
        int pc_cyc = 0;
        logic rw_seen = 0;
        write_reg = 0; write_mem = 1; imem_ack = 1; dmem_ack = 0; step = 1;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            tick();
            if (cyc == 1) step = 0;
            if (dmem_we) we_cnt++;
            if (pc_en && pc_cyc == 0) pc_cyc = cyc;
            if (reg_we) rw_seen = 1;
            if (cyc == 7) dmem_ack = 1;
            if (cyc == 8) dmem_ack = 0;
        end
        total++; if (we_cnt != 4) $display("FAIL store_we_cycles got=%0d exp=4", we_cnt); else passed++;
        total++; if (pc_cyc != 8) $display("FAIL store_pc_en_cycle got=%0d exp=8", pc_cyc); else passed++;
        total++; if (rw_seen !== 1'b0) $display("FAIL store_reg_we got=%b exp=0", rw_seen); else passed++;
        total++; if (state !== ST_IDLE || instret !== 32'd2 || cycle_cnt !== 32'd12)
            $display("FAIL store_end state=%0d instret=%0d cycle=%0d exp=0/2/12", state, instret, cycle_cnt); else passed++;
        write_mem = 0;
    endtask

    task automatic test_step();
        int pcs = 0;
        write_reg = 1; imem_ack = 1; step = 1;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            tick();
            if (pc_en) pcs++;
            if (cyc == 1) step = 0;
            if (cyc == 3) begin
                total++; if (state !== ST_EXEC) $display("FAIL step_exec state=%0d exp=3", state); else passed++;
                step = 1;
            end
            if (cyc == 4) step = 0;
        end
        total++; if (pcs != 1) $display("FAIL step_wb_count got=%0d exp=1", pcs); else passed++;
        total++; if (state !== ST_IDLE || instret !== 32'd3 || cycle_cnt !== 32'd16)
            $display("FAIL step_end state=%0d instret=%0d cycle=%0d exp=0/3/16", state, instret, cycle_cnt); else passed++;
    endtask

    task automatic test_back_to_back();
        write_reg = 1; imem_ack = 1; run = 1;
        wait_state(ST_WB, 8, "b2b_first_wb");
        tick();
        total++; if (state !== ST_FETCH || busy !== 1'b1 || imem_req !== 1'b1)
            $display("FAIL b2b_refetch state=%0d busy=%b req=%b exp=1/1/1", state, busy, imem_req); else passed++;
        run = 0;
        wait_state(ST_IDLE, 8, "b2b_stop");
        total++; if (instret !== 32'd5 || cycle_cnt !== 32'd24)
            $display("FAIL b2b_counters instret=%0d cycle=%0d exp=5/24", instret, cycle_cnt); else passed++;
    endtask

    task automatic test_halt();
        int pcs = 0;
        int off = 0;
        do_reset();
        halt_insn = 1; imem_ack = 1; run = 1;
        tick(); tick(); tick();
        total++; if (state !== ST_HALT || halted !== 1'b1 || busy !== 1'b0)
            $display("FAIL halt_enter state=%0d halted=%b busy=%b exp=6/1/0", state, halted, busy); else passed++;
        for (int cyc = 0; cyc < 6; cyc++) begin
            step = cyc[0];
            tick();
            if (pc_en) pcs++;
            if (state !== ST_HALT) off++;
        end
        step = 0; run = 0;
        total++; if (pcs != 0 || off != 0) $display("FAIL halt_sticky pc_en_cycles=%0d left_halt=%0d exp=0/0", pcs, off); else passed++;
        total++; if (instret !== 32'd0) $display("FAIL halt_instret got=%0d exp=0", instret); else passed++;
        halt_insn = 0;
        do_reset();
        total++; if (state !== ST_IDLE || halted !== 1'b0) $display("FAIL halt_reset state=%0d halted=%b exp=0/0", state, halted); else passed++;
    endtask

    task automatic test_timeout();
        imem_ack = 0; write_reg = 0; step = 1;
        tick(); step = 0;
        tick(); tick(); tick();
        total++; if (state !== ST_FETCH || imem_req !== 1'b1)
            $display("FAIL tmo_limit_cycle state=%0d req=%b exp=1/1", state, imem_req); else passed++;
        imem_ack = 1;
        #1;
        total++; if (ir_load !== 1'b1) $display("FAIL tmo_ir_load got=%b exp=1", ir_load); else passed++;
        tick();
        total++; if (state !== ST_DECODE) $display("FAIL tmo_ack_wins state=%0d exp=2", state); else passed++;
        imem_ack = 0;
        wait_state(ST_IDLE, 6, "tmo_complete");
        step = 1;
        tick(); step = 0;
        tick(); tick(); tick();
        total++; if (state !== ST_FETCH) $display("FAIL tmo_still_fetch state=%0d exp=1", state); else passed++;
        tick();
        total++; if (state !== ST_ERROR || error !== 1'b1 || imem_req !== 1'b0 || busy !== 1'b0)
            $display("FAIL tmo_error state=%0d error=%b req=%b busy=%b exp=7/1/0/0", state, error, imem_req, busy); else passed++;
        run = 1; imem_ack = 1; step = 1;
        tick(); step = 0; tick(); tick();
        total++; if (state !== ST_ERROR) $display("FAIL tmo_sticky state=%0d exp=7", state); else passed++;
        run = 0; imem_ack = 0;
        do_reset();
        total++; if (error !== 1'b0 || state !== ST_IDLE) $display("FAIL tmo_reset error=%b state=%0d exp=0/0", error, state); else passed++;
    endtask

    task automatic test_reset_mid_mem();
        int pcs = 0;
        write_mem = 1; write_reg = 1; imem_ack = 1; dmem_ack = 0; step = 1;
        tick(); step = 0;
        tick(); tick(); tick();
        total++; if (state !== ST_MEM || dmem_req !== 1'b1 || dmem_we !== 1'b1)
            $display("FAIL rstmem_in_mem state=%0d dreq=%b dwe=%b exp=4/1/1", state, dmem_req, dmem_we); else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++; if ({dmem_req, dmem_we, pc_en, reg_we, busy, imem_req, ir_load} !== 7'd0 || state !== ST_IDLE)
            $display("FAIL rstmem_async outs=%b state=%0d exp=0000000/0", {dmem_req, dmem_we, pc_en, reg_we, busy, imem_req, ir_load}, state); else passed++;
        total++; if (cycle_cnt !== 32'd0 || instret !== 32'd0)
            $display("FAIL rstmem_counters cycle=%0d instret=%0d exp=0/0", cycle_cnt, instret); else passed++;
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int cyc = 0; cyc < 4; cyc++) begin
            tick();
            if (pc_en || reg_we) pcs++;
        end
        total++; if (pcs != 0 || instret !== 32'd0 || state !== ST_IDLE)
            $display("FAIL rstmem_no_commit commits=%0d instret=%0d state=%0d exp=0/0/0", pcs, instret, state); else passed++;
        write_mem = 0; write_reg = 0;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_store();
        test_step();
        test_back_to_back();
        test_halt();
        test_timeout();
        test_reset_mid_mem();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
